// File: rtl/relu_maxpool2x2.sv
// relu_maxpool2x2: streaming 2x2 stride-2 signed max pool.
// Keeps horizontal pair maxima of even rows in a half-width line buffer.
module relu_maxpool2x2 #(
    parameter int RESULT = 10,
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RESULT-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RESULT-1:0] out_data,
    output logic              frame_done
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int HW = IMG_W / 2;
    localparam int HB = (HW > 1) ? $clog2(HW) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [RESULT-1:0] pair;
    logic [RESULT-1:0] h_max;
    logic [RESULT-1:0] v_max;
    logic [RESULT-1:0] line_buf [HW];
    logic [HB-1:0]     half;
    logic              accept;
    logic              load;
    logic              last_win;

    function automatic logic [RESULT-1:0] smax(
        input logic [RESULT-1:0] a,
        input logic [RESULT-1:0] b
    );
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign half     = HB'(col >> 1);
    assign h_max    = smax(pair, in_data);
    assign v_max    = smax(line_buf[half], h_max);
    assign load     = accept && col[0] && row[0];
    assign last_win = (col == COL_LAST) && (row == ROW_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            pair       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= load && last_win;
            // a new window replaces a result consumed on the same edge
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= v_max;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (!col[0]) pair <= in_data;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && col[0] && !row[0]) line_buf[half] <= h_max;
    end
endmodule
